// File: rtl/mac_operand_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mac_operand_sequencer_pkg
// Shared widths, FSM state encoding and a small helper for the MAC operand
// sequencer and its operand buffer.
//   OP_W    : width of one MAC operand
//   ACC_W   : width of the MAC accumulated result
//   PAIR_W  : width of one stored operand pair {a, b}
//   state_t : sequencer FSM states IDLE -> GO -> FEED -> WAIT -> DONE
// -----------------------------------------------------------------------------
package mac_operand_sequencer_pkg;

    localparam int OP_W   = 4;
    localparam int ACC_W  = 12;
    localparam int PAIR_W = 2 * OP_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GO   = 3'd1,
        ST_FEED = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // A start is only honoured for a sequence length of 1..depth pairs.
    function automatic logic len_ok(input int unsigned len, input int unsigned depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/mac_operand_sequencer_buffer.sv
// -----------------------------------------------------------------------------
// mac_operand_sequencer_buffer
// DEPTH x PAIR_W register file holding the operand pairs the sequencer streams
// to the MAC. One synchronous write port, one combinational read port.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset, clears every entry
//   wr_en_i    : write strobe (already qualified by the caller)
//   wr_addr_i  : write address
//   wr_data_i  : pair to store, {a, b}
//   rd_addr_i  : read address
//   rd_data_o  : pair at rd_addr_i, {a, b}
// -----------------------------------------------------------------------------
module mac_operand_sequencer_buffer
    import mac_operand_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [PAIR_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [PAIR_W-1:0] rd_data_o
);

    logic [DEPTH-1:0][PAIR_W-1:0] entries;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PAIR_W-1:0] entry_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (wr_en_i && (wr_addr_i == ADDR_W'(gi))) begin
                    entry_q <= wr_data_i;
                end
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    assign rd_data_o = entries[rd_addr_i];

endmodule

// File: rtl/mac_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mac_operand_sequencer
// Initiator side of the MAC go/operand/done interface. A host loads operand
// pairs into a small buffer; on start the block pulses mac_go_o, streams the
// pairs one beat (BEAT_CYCLES cycles) each, waits for mac_done_i and captures
// the accumulated result.
//   clk             : clock, rising edge
//   rst             : asynchronous active-high reset
//   wr_en_i         : write one pair into the buffer (dropped while busy)
//   wr_addr_i       : buffer write address
//   wr_a_i, wr_b_i  : operand pair to write
//   start_i         : begin a sequence (ignored while busy or len invalid)
//   len_i           : number of pairs to send, 1..DEPTH, sampled on start
//   busy_o          : high from the cycle after an accepted start until DONE exits
//   result_o        : last captured mac_out_i, held until the next capture
//   result_valid_o  : one-cycle pulse in DONE when result_o was updated
//   err_o           : sticky timeout / early-done flag, cleared by accepted start
//   mac_go_o        : one-cycle start pulse to the MAC
//   mac_a_o,mac_b_o : current operand pair
//   mac_out_i       : MAC accumulated result
//   mac_done_i      : MAC completion level
// -----------------------------------------------------------------------------
module mac_operand_sequencer
    import mac_operand_sequencer_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int BEAT_CYCLES = 3,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [OP_W-1:0]   wr_a_i,
    input  logic [OP_W-1:0]   wr_b_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic [ACC_W-1:0]  result_o,
    output logic              result_valid_o,
    output logic              err_o,
    output logic              mac_go_o,
    output logic [OP_W-1:0]   mac_a_o,
    output logic [OP_W-1:0]   mac_b_o,
    input  logic [ACC_W-1:0]  mac_out_i,
    input  logic              mac_done_i
);

    localparam int BEAT_W = $clog2(BEAT_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    state_t              state_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                busy_q;
    logic [ACC_W-1:0]    result_q;
    logic                result_valid_q;
    logic                err_q;
    logic                mac_go_q;
    logic [OP_W-1:0]     mac_a_q;
    logic [OP_W-1:0]     mac_b_q;

    logic                wr_fire;
    logic                start_ok;
    logic                last_beat;
    logic                last_pair;
    logic [ADDR_W-1:0]   rd_addr_d;
    logic [PAIR_W-1:0]   rd_data;
    logic [PAIR_W-1:0]   pair_d;

    // The buffer is frozen for the whole sequence.
    assign wr_fire  = wr_en_i && !busy_q;
    assign start_ok = start_i && len_ok(32'(len_i), 32'(DEPTH));

    // The read port always looks one pair ahead: pair 0 while idle (to be
    // registered on the start edge), otherwise the pair after the current one.
    assign rd_addr_d = (state_q == ST_IDLE) ? '0 : idx_q + 1'b1;

    // A write landing in the same cycle as an accepted start must already be
    // visible to the sequence, so forward it around the buffer.
    assign pair_d = (wr_fire && (wr_addr_i == rd_addr_d)) ? {wr_a_i, wr_b_i} : rd_data;

    assign last_beat = (beat_q == BEAT_W'(BEAT_CYCLES - 1));
    assign last_pair = ({1'b0, idx_q} == (len_q - 1'b1));

    mac_operand_sequencer_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_addr_i),
        .wr_data_i ({wr_a_i, wr_b_i}),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            idx_q          <= '0;
            beat_q         <= '0;
            tmo_q          <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            mac_go_q       <= 1'b0;
            mac_a_q        <= '0;
            mac_b_q        <= '0;
        end else begin
            mac_go_q       <= 1'b0;
            result_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_q                <= len_i;
                        idx_q                <= '0;
                        beat_q               <= '0;
                        tmo_q                <= '0;
                        err_q                <= 1'b0;
                        busy_q               <= 1'b1;
                        mac_go_q             <= 1'b1;
                        {mac_a_q, mac_b_q}   <= pair_d;
                        state_q              <= ST_GO;
                    end
                end

                // Pair 0 is already on the bus; the GO cycle is not part of its beat.
                ST_GO: begin
                    state_q <= ST_FEED;
                end

                ST_FEED: begin
                    if (mac_done_i) begin
                        // MAC finished before all pairs were sent.
                        result_q       <= mac_out_i;
                        result_valid_q <= 1'b1;
                        err_q          <= 1'b1;
                        state_q        <= ST_DONE;
                    end else if (last_beat) begin
                        beat_q <= '0;
                        if (last_pair) begin
                            state_q <= ST_WAIT;
                        end else begin
                            idx_q              <= idx_q + 1'b1;
                            {mac_a_q, mac_b_q} <= pair_d;
                        end
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (mac_done_i) begin
                        result_q       <= mac_out_i;
                        result_valid_q <= 1'b1;
                        state_q        <= ST_DONE;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign err_o          = err_q;
    assign mac_go_o       = mac_go_q;
    assign mac_a_o        = mac_a_q;
    assign mac_b_o        = mac_b_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_EARLY  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en_i = 1'b0;
    logic [3:0]  wr_addr_i = '0;
    logic [3:0]  wr_a_i = '0;
    logic [3:0]  wr_b_i = '0;
    logic        start_i = 1'b0;
    logic [4:0]  len_i = '0;
    logic        busy_o;
    logic [11:0] result_o;
    logic        result_valid_o;
    logic        err_o;
    logic        mac_go_o;
    logic [3:0]  mac_a_o;
    logic [3:0]  mac_b_o;
    logic [11:0] mac_out_i = '0;
    logic        mac_done_i = 1'b0;

    mac_operand_sequencer #(
        .DEPTH       (16),
        .ADDR_W      (4),
        .BEAT_CYCLES (3),
        .TIMEOUT     (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (wr_en_i),
        .wr_addr_i      (wr_addr_i),
        .wr_a_i         (wr_a_i),
        .wr_b_i         (wr_b_i),
        .start_i        (start_i),
        .len_i          (len_i),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .err_o          (err_o),
        .mac_go_o       (mac_go_o),
        .mac_a_o        (mac_a_o),
        .mac_b_o        (mac_b_o),
        .mac_out_i      (mac_out_i),
        .mac_done_i     (mac_done_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]       len;
        logic [15:0][3:0] a;
        logic [15:0][3:0] b;
        logic [1:0]       mode;
        logic             poke;       // busy-time write + start attempts
        logic [11:0]      exp_result;
        logic             exp_err;
        logic             exp_rv;
        logic [7:0]       exp_end;    // cycle (GO = 0) at which busy is seen low
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Writes all pairs of vector v; the last write shares its cycle with start.
    task automatic load_and_start(input int v);
        int len;
        len = int'(vecs[v].len);
        for (int i = 0; i < len - 1; i++) begin
            @(negedge clk);
            wr_en_i   = 1'b1;
            wr_addr_i = 4'(i);
            wr_a_i    = vecs[v].a[i];
            wr_b_i    = vecs[v].b[i];
        end
        @(negedge clk);
        wr_en_i   = 1'b1;
        wr_addr_i = 4'(len - 1);
        wr_a_i    = vecs[v].a[len-1];
        wr_b_i    = vecs[v].b[len-1];
        start_i   = 1'b1;
        len_i     = vecs[v].len;
    endtask

    task automatic run_vec(input int v);
        int          c, len, go_cnt, rv_cnt, hold_err, end_c, k, mode;
        logic [11:0] acc;
        len = int'(vecs[v].len);
        mode = int'(vecs[v].mode);
        c = -1; go_cnt = 0; rv_cnt = 0; hold_err = 0; end_c = -1; acc = '0;
        load_and_start(v);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            wr_en_i = 1'b0;
            start_i = 1'b0;
            if (mac_go_o) begin
                go_cnt++;
                c   = 0;
                acc = '0;
                if (mac_a_o !== vecs[v].a[0] || mac_b_o !== vecs[v].b[0]) hold_err++;
            end else if (c >= 0) begin
                c++;
            end
            // MAC model: take each pair on the first cycle of its beat.
            if (c >= 1 && c <= 3 * len) begin
                k = (c - 1) / 3;
                if (mac_a_o !== vecs[v].a[k] || mac_b_o !== vecs[v].b[k]) hold_err++;
                if ((c - 1) % 3 == 0) acc = acc + 12'(mac_a_o) * 12'(mac_b_o);
            end
            mac_out_i  = acc;
            mac_done_i = (mode == MODE_NORMAL && c == 3 * len + 2) ||
                         (mode == MODE_EARLY && c == 4);
            if (vecs[v].poke && c == 2) begin
                wr_en_i = 1'b1; wr_addr_i = 4'd3; wr_a_i = 4'd0; wr_b_i = 4'd0;
            end
            if (vecs[v].poke && c == 5) begin
                start_i = 1'b1; len_i = 5'd2;
            end
            if (result_valid_o) rv_cnt++;
            if (c > 0 && !busy_o) begin
                end_c = c;
                break;
            end
        end
        mac_done_i = 1'b0;
        wr_en_i    = 1'b0;
        start_i    = 1'b0;
        $display("vec %0d: len=%0d mode=%0d result=%0d err=%0b rv=%0d go=%0d end=%0d",
                 v, len, mode, result_o, err_o, rv_cnt, go_cnt, end_c);
        chk($sformatf("v%0d_go_pulses", v), go_cnt, 1);
        chk($sformatf("v%0d_pair_hold", v), hold_err, 0);
        chk($sformatf("v%0d_result_valid", v), rv_cnt, int'(vecs[v].exp_rv));
        chk($sformatf("v%0d_result", v), int'(result_o), int'(vecs[v].exp_result));
        chk($sformatf("v%0d_err", v), int'(err_o), int'(vecs[v].exp_err));
        chk($sformatf("v%0d_end_cycle", v), end_c, int'(vecs[v].exp_end));
    endtask

    task automatic bad_start(input logic [4:0] l);
        int go_cnt, busy_cnt;
        go_cnt = 0; busy_cnt = 0;
        @(negedge clk);
        start_i = 1'b1;
        len_i   = l;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (mac_go_o) go_cnt++;
            if (busy_o) busy_cnt++;
        end
        $display("bad start len=%0d: go=%0d busy_cycles=%0d", l, go_cnt, busy_cnt);
        chk($sformatf("bad_len%0d_go", l), go_cnt, 0);
        chk($sformatf("bad_len%0d_busy", l), busy_cnt, 0);
    endtask

    function automatic int out_bits();
        return int'({busy_o, result_valid_o, err_o, mac_go_o, mac_a_o, mac_b_o, result_o});
    endfunction

    initial begin
        int c;

        // Vector table
        for (int i = 0; i < 5; i++) vecs[i] = '0;
        vecs[0].len = 5'd4;
        vecs[0].a[0] = 4'd3;  vecs[0].b[0] = 4'd5;
        vecs[0].a[1] = 4'd2;  vecs[0].b[1] = 4'd7;
        vecs[0].a[2] = 4'd15; vecs[0].b[2] = 4'd15;
        vecs[0].a[3] = 4'd1;  vecs[0].b[3] = 4'd1;
        vecs[0].mode = 2'(MODE_NORMAL); vecs[0].poke = 1'b1;
        vecs[0].exp_result = 12'd255; vecs[0].exp_err = 1'b0; vecs[0].exp_rv = 1'b1;
        vecs[0].exp_end = 8'd16;

        vecs[1] = vecs[0];
        vecs[1].mode = 2'(MODE_NEVER); vecs[1].poke = 1'b0;
        vecs[1].exp_result = 12'd255; vecs[1].exp_err = 1'b1; vecs[1].exp_rv = 1'b0;
        vecs[1].exp_end = 8'd78;

        vecs[2].len = 5'd16;
        for (int i = 0; i < 16; i++) begin
            vecs[2].a[i] = 4'd15; vecs[2].b[i] = 4'd15;
        end
        vecs[2].mode = 2'(MODE_NORMAL);
        vecs[2].exp_result = 12'hE10; vecs[2].exp_err = 1'b0; vecs[2].exp_rv = 1'b1;
        vecs[2].exp_end = 8'd52;

        vecs[3] = vecs[0];
        vecs[3].mode = 2'(MODE_EARLY); vecs[3].poke = 1'b0;
        vecs[3].exp_result = 12'd29; vecs[3].exp_err = 1'b1; vecs[3].exp_rv = 1'b1;
        vecs[3].exp_end = 8'd6;

        vecs[4].len = 5'd1;
        vecs[4].a[0] = 4'd7; vecs[4].b[0] = 4'd9;
        vecs[4].mode = 2'(MODE_NORMAL);
        vecs[4].exp_result = 12'd63; vecs[4].exp_err = 1'b0; vecs[4].exp_rv = 1'b1;
        vecs[4].exp_end = 8'd7;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("reset: outputs=0x%0h", out_bits());
        chk("reset_outputs", out_bits(), 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(v);

        // Invalid lengths
        bad_start(5'd0);
        bad_start(5'd17);

        // Reset in the middle of FEED while pair 2 is on the bus
        load_and_start(0);
        c = -1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            wr_en_i = 1'b0;
            start_i = 1'b0;
            if (mac_go_o) c = 0;
            else if (c >= 0) c++;
            if (c == 7) break;
        end
        chk("mid_reach_idx2", c, 7);
        chk("mid_pair2_a", int'(mac_a_o), 15);
        #1 rst = 1'b1;
        #1;
        $display("mid-feed reset: outputs=0x%0h", out_bits());
        chk("mid_reset_outputs", out_bits(), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
